// File: rtl/instr_line_server.sv
// instr_line_server
//
// Instruction-side memory responder for the fetch path. A line request
// (read_enable + pc) is captured while idle, and LATENCY edges later the
// LINE_WORDS consecutive words starting at pc (wrapping at DEPTH) are
// delivered in a single beat on instr, marked by a one-cycle instr_valid.
// A word-wide load port preloads the store and is accepted in every state.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset (store contents are kept)
//   read_enable  fetch request, ignored while busy
//   pc           word address of the first word of the requested line
//   instr        delivered line, instr[k] = mem[(pc + k) mod DEPTH]
//   instr_valid  one-cycle pulse marking a new line on instr
//   busy         high while a request is outstanding
//   load_en      preload write strobe
//   load_addr    preload word address
//   load_data    preload word, bit 0 = MSB
module instr_line_server #(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int LINE_WORDS = 16,
  parameter int LATENCY    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] pc,
  output logic [0:31]       instr [0:LINE_WORDS-1],
  output logic              instr_valid,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [0:31]       load_data
);

  // Countdown holds LATENCY-1 at most; keep at least one bit for LATENCY=1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] req_pc;
  logic              deliver;
  logic [0:31]       mem [0:DEPTH-1];

  assign busy    = (state == WAIT);
  assign deliver = (state == WAIT) && (count == '0);

  // Request capture / countdown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= deliver;
      case (state)
        IDLE: begin
          if (read_enable) begin
            state <= WAIT;
            count <= CNT_W'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (count == '0) begin
            state <= IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The captured address is only consumed while in WAIT, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && read_enable) begin
      req_pc <= pc;
    end
  end

  // Store: never cleared, so a program loaded before reset survives it.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Line delivery. The read happens on the same edge as any load, so a load
  // coinciding with delivery is not seen by that line (old value is read).
  // The ADDR_W-bit sum wraps naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        instr[k] <= '0;
      end
    end else if (deliver) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        instr[k] <= mem[req_pc + ADDR_W'(k)];
      end
    end
  end

endmodule

// File: tb/tb_instr_line_server.sv
// Testbench for instr_line_server: directed scenarios followed by random
// requests and loads, checked by a scoreboard fed from a reference model.
module tb_instr_line_server;

  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic        read_enable;
  logic [7:0]  pc;
  logic [0:31] instr [0:15];
  logic        instr_valid;
  logic        busy;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [0:31] load_data;

  instr_line_server #(
    .DEPTH(256), .ADDR_W(8), .LINE_WORDS(16), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .read_enable(read_enable), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .busy(busy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain word array plus "at most one outstanding
  // request, answered LAT edges after it was accepted".
  logic [31:0] mmem [0:255];
  int          cyc = 0;
  bit          pend = 0;
  int          pend_pc = 0;
  int          due = 0;
  logic [31:0] exp_words [$];
  int          exp_due [$];

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      pend = 0;
    end else if (pend && cyc == due) begin
      for (int k = 0; k < 16; k++) exp_words.push_back(mmem[(pend_pc + k) % 256]);
      exp_due.push_back(cyc);
      pend = 0;
    end else if (!pend && read_enable) begin
      pend    = 1;
      pend_pc = int'(pc);
      due     = cyc + LAT;
    end
    if (load_en) mmem[load_addr] = load_data;
  end

  // Snapshots taken by the driver right after an asynchronous reset assertion.
  int          snap_id = 0;
  logic        snap_busy, snap_valid;
  logic [31:0] snap_or;
  bit          fin_req = 0;

  // Monitor / scoreboard
  int          total = 0;
  int          bad = 0;
  int          rd_idx = 0;
  int          seen_snap = 0;
  bit          fin_done = 0;
  logic [31:0] last_line [0:15];

  task automatic chk(input bit ok, input string name, input longint got, input longint want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  initial for (int k = 0; k < 16; k++) last_line[k] = '0;

  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 16; k++) last_line[k] = '0;
    end
    if (snap_id != seen_snap) begin
      seen_snap = snap_id;
      chk(snap_busy == 1'b0, "reset_busy", longint'(snap_busy), 0);
      chk(snap_valid == 1'b0, "reset_valid", longint'(snap_valid), 0);
      chk(snap_or == 32'h0, "reset_instr", longint'(snap_or), 0);
    end
    chk(busy === (pend && reset), "busy", longint'(busy), longint'(pend && reset));
    if (instr_valid === 1'b1) begin
      if (rd_idx >= exp_due.size()) begin
        chk(1'b0, "unexpected_valid", 1, 0);
      end else begin
        bit ok = 1'b1;
        int wk = 0;
        for (int k = 15; k >= 0; k--) begin
          if (instr[k] !== exp_words[rd_idx*16 + k]) begin
            ok = 1'b0;
            wk = k;
          end
        end
        chk(ok, $sformatf("line_word%0d", wk), longint'(instr[wk]),
            longint'(exp_words[rd_idx*16 + wk]));
        chk(exp_due[rd_idx] == cyc, "delivery_cycle", cyc, exp_due[rd_idx]);
        for (int k = 0; k < 16; k++) last_line[k] = exp_words[rd_idx*16 + k];
        rd_idx++;
      end
    end else begin
      bit ok = 1'b1;
      int wk = 0;
      for (int k = 15; k >= 0; k--) begin
        if (instr[k] !== last_line[k]) begin
          ok = 1'b0;
          wk = k;
        end
      end
      chk(ok, $sformatf("hold_word%0d", wk), longint'(instr[wk]), longint'(last_line[wk]));
    end
    if (fin_req && !fin_done) begin
      fin_done = 1'b1;
      chk(rd_idx == exp_due.size(), "missing_delivery", rd_idx, exp_due.size());
      chk(!pend, "request_outstanding", longint'(pend), 0);
    end
  end

  // Driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    read_enable = 1'b0;
    load_en     = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic request(input logic [7:0] a);
    read_enable = 1'b1;
    pc          = a;
    step();
    read_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b0; read_enable = 1'b0; pc = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    step(); step();
    reset = 1'b1;
    step();

    // Preload mem[i] = i
    for (int i = 0; i < 256; i++) begin
      load_en = 1'b1; load_addr = 8'(i); load_data = 32'(i);
      step();
    end
    idle(1);

    // Basic fetch and wrap-around
    request(8'd0);
    idle(5);
    request(8'd250);
    idle(5);

    // Requests held high while busy are dropped; still high at E4 -> second line
    read_enable = 1'b1; pc = 8'd16;
    step();
    pc = 8'd32;
    step(); step(); step(); step();
    read_enable = 1'b0;
    idle(6);

    // Load collision: load on E1 is seen, load on the delivery edge is not
    request(8'd0);
    load_en = 1'b1; load_addr = 8'd5; load_data = 32'hDEADBEEF;
    step();
    load_en = 1'b0;
    step();
    load_en = 1'b1; load_addr = 8'd6; load_data = 32'hCAFEF00D;
    step();
    load_en = 1'b0;
    idle(4);

    // Reset in the middle of WAIT discards the request
    request(8'd8);
    step();
    #2;
    reset = 1'b0;
    #1;
    snap_busy  = busy;
    snap_valid = instr_valid;
    snap_or    = '0;
    for (int k = 0; k < 16; k++) snap_or = snap_or | instr[k];
    snap_id++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    request(8'd4);
    idle(6);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      read_enable = ($urandom_range(0, 2) == 0);
      pc          = 8'($urandom_range(0, 255));
      load_en     = ($urandom_range(0, 3) == 0);
      load_addr   = 8'($urandom_range(0, 255));
      load_data   = $urandom;
      step();
    end
    idle(8);

    fin_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_line_server.md
# instr_line_server

Instruction-side memory responder for the SPU fetch path. Serves the fetch unit's line requests (`read_enable` plus 8-bit word `pc`): after a fixed latency it returns 16 consecutive 32-bit instruction words in one beat on `instr[0:15]`. It replaces the behavioural instruction memory and has a word-wide load port for program preload.

## Interface

Parameters:
- `DEPTH`, 256: number of 32-bit words in the instruction store. Must be 2**ADDR_W.
- `ADDR_W`, 8: word-address width; matches the `pc` width.
- `LINE_WORDS`, 16: words returned per request.
- `LATENCY`, 3: cycles from request capture to delivery. Must be ≥1.

Ports (clock and reset first):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset: asynchronous, active-low (0 = reset).
- `read_enable`  in  1  fetch request, sampled on the rising edge.
- `pc`  in  ADDR_W  word address of the first word of the requested line.
- `instr`  out  LINE_WORDS×32 (`[0:31] instr[0:15]`)  delivered line; `instr[k]` = mem[(pc+k) mod DEPTH].
- `instr_valid`  out  1  one-cycle pulse marking a new line on `instr`.
- `busy`  out  1  high while a request is outstanding; requests are ignored while high.
- `load_en`  in  1  preload write strobe.
- `load_addr`  in  ADDR_W  preload word address.
- `load_data`  in  32 (`[0:31]`)  preload word, bit 0 = MSB.

## Operation

- Storage: DEPTH×32 array. The array is not cleared by reset, so its contents survive reset.
- FSM states:
  - IDLE: `busy`=0. On an edge with `read_enable`=1, capture `pc` into `req_pc`, load the countdown with LATENCY-1, and go to WAIT.
  - WAIT: `busy`=1. Decrement the countdown each edge. On the edge where the countdown is 0, go to DELIVER actions (next bullet).
  - DELIVER actions, done on that same edge: assemble the line from the array, load `instr`, pulse `instr_valid` for one cycle, and return to IDLE.
- Address arithmetic: word k = mem[(req_pc + k) mod DEPTH], computed as ADDR_W-bit addition that wraps naturally. No alignment is required.
- `instr` holds the last delivered line until the next delivery. It does not change on request capture.
- `read_enable` while `busy`=1 is dropped. There is no queue and no error flag; the fetch unit must re-issue.
- Load port: on an edge with `load_en`=1, write mem[load_addr] = load_data. Loads are accepted in every state.
- Read/write collision: a line assembled on edge E sees the array as it was before E. A load on E itself is not visible to that line; loads on earlier edges are.
- `pc` changes after capture have no effect on the outstanding request.

## Timing

- Reset asserted (`reset`=0): immediately, asynchronously, `instr` all words = 0, `instr_valid`=0, `busy`=0, and the FSM goes to IDLE. Any outstanding request is discarded and never delivered.
- Release of reset is synchronous to `clk`. The first request can be captured on the first rising edge with `reset`=1.
- Request captured on edge E0:
  - `busy`=1 from after E0 until after E_LATENCY.
  - `instr` and `instr_valid`=1 appear after edge E_LATENCY (LATENCY edges after E0).
  - `instr_valid` returns to 0 after E_LATENCY+1.
- Throughput: `busy` falls with the delivery edge, so the next request is capturable on E_LATENCY+1. That gives one line per LATENCY+1 cycles.
- A request asserted on the delivery edge E_LATENCY is ignored, because `busy` was 1 before that edge.
- The load port is single-cycle and has no back-pressure.

## Test plan

- Reset values: drive `reset`=0 mid-simulation. Check `instr`=0, `instr_valid`=0, `busy`=0 without a clock edge. A pending request started before reset must never produce `instr_valid`.
- Basic fetch: preload mem[i]=i for i in 0..255, request `pc`=0 at E0 with LATENCY=3. Check `busy`=1 after E0..E2, then after E3 `instr[k]`=k for k=0..15, `instr_valid`=1 for exactly one cycle, and `busy`=0.
- Wrap-around: same preload, request `pc`=250. Check `instr[0..5]`=250..255 and `instr[6..15]`=0..9.
- Busy drop: request `pc`=16 at E0, then `pc`=32 with `read_enable` held through E1..E3. Check a single delivery of words 16..31. A second delivery (32..47) occurs only if `read_enable` is still 1 at E4, and arrives after E7.
- Load collision: request `pc`=0 at E0. Load mem[5]=32'hDEADBEEF at E1 and mem[6]=32'hCAFEF00D at E3. Check `instr[5]`=DEADBEEF and `instr[6]`=6 (old value).
- Reset mid-WAIT: request at E0, assert `reset`=0 between E1 and E2, release, then request `pc`=4. Check only the `pc`=4 line is delivered (words 4..19), LATENCY edges after its capture.
